// File: rtl/up_counter_4bit_ld.sv
// 4-bit synchronous up counter with parallel load, count enable and terminal-count flag.
// Latency: load and increment visible on pout one cycle after the sampling edge; co is a decode of pout.
// Backpressure: none; ld/cnt are sampled every edge, and cnt low holds the count indefinitely.
module up_counter_4bit_ld (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic       cnt,
    input  logic [3:0] pin,
    output logic [3:0] pout,
    output logic       co
);

    logic [3:0] pout_d;
    logic [3:0] pout_q;

    // Load wins over count; the 4-bit add wraps F -> 0 naturally.
    always_comb begin
        pout_d = pout_q;
        if (ld) begin
            pout_d = pin;
        end else if (cnt) begin
            pout_d = pout_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pout_q <= 4'h0;
        end else begin
            pout_q <= pout_d;
        end
    end

    assign pout = pout_q;
    assign co   = (pout_q == 4'hF);

endmodule

// File: tb/tb_up_counter_4bit_ld.sv
// Directed self-checking bench for up_counter_4bit_ld.
module tb_up_counter_4bit_ld;

    logic       clk;
    logic       rst;
    logic       ld;
    logic       cnt;
    logic [3:0] pin;
    logic [3:0] pout;
    logic       co;

    int n_checks;
    int n_fail;

    up_counter_4bit_ld dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .cnt  (cnt),
        .pin  (pin),
        .pout (pout),
        .co   (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld = 1'b1; cnt = 1'b1; pin = 4'hA;
        step();
        n_checks++;
        if (pout !== 4'h0) begin n_fail++; $display("FAIL reset_pout_1: got %h want 0", pout); end
        n_checks++;
        if (co !== 1'b0) begin n_fail++; $display("FAIL reset_co_1: got %b want 0", co); end
        step();
        n_checks++;
        if (pout !== 4'h0) begin n_fail++; $display("FAIL reset_pout_2: got %h want 0", pout); end
        rst = 1'b0; ld = 1'b0; cnt = 1'b1;
        step();
        n_checks++;
        if (pout !== 4'h1) begin n_fail++; $display("FAIL reset_release: got %h want 1", pout); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_p;
        rst = 1'b1; ld = 1'b0; cnt = 1'b0;
        step();
        rst = 1'b0; cnt = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            exp_p = 4'(i % 16);
            n_checks++;
            if (pout !== exp_p) begin n_fail++; $display("FAIL wrap_pout[%0d]: got %h want %h", i, pout, exp_p); end
            n_checks++;
            if (co !== (exp_p == 4'hF)) begin n_fail++; $display("FAIL wrap_co[%0d]: got %b want %b", i, co, exp_p == 4'hF); end
        end
        cnt = 1'b0;
    endtask

    task automatic test_load_priority();
        rst = 1'b1; ld = 1'b0; cnt = 1'b0;
        step();
        rst = 1'b0; cnt = 1'b1;
        step(); step(); step();
        n_checks++;
        if (pout !== 4'h3) begin n_fail++; $display("FAIL ldpri_setup: got %h want 3", pout); end
        ld = 1'b1; pin = 4'hC;
        step();
        n_checks++;
        if (pout !== 4'hC) begin n_fail++; $display("FAIL ldpri_load: got %h want c", pout); end
        ld = 1'b0; pin = 4'h0;
        step(); step();
        n_checks++;
        if (co !== 1'b0) begin n_fail++; $display("FAIL ldpri_co_early: got %b want 0", co); end
        step();
        n_checks++;
        if (pout !== 4'hF) begin n_fail++; $display("FAIL ldpri_count: got %h want f", pout); end
        n_checks++;
        if (co !== 1'b1) begin n_fail++; $display("FAIL ldpri_co: got %b want 1", co); end
        cnt = 1'b0;
    endtask

    task automatic test_hold();
        ld = 1'b1; cnt = 1'b0; pin = 4'h7;
        step();
        ld = 1'b0; pin = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (pout !== 4'h7 || co !== 1'b0) begin
                n_fail++; $display("FAIL hold[%0d]: got pout=%h co=%b want pout=7 co=0", i, pout, co);
            end
        end
    endtask

    task automatic test_equiv();
        logic [3:0] d;
        for (int di = 1; di <= 15; di++) begin
            d = 4'(di);
            ld = 1'b1; cnt = 1'b0; pin = ~d;
            step();
            ld = 1'b0;
            for (int k = 1; k <= di; k++) begin
                cnt = 1'b1;
                step();
                cnt = 1'b0;
                n_checks++;
                if (co !== (k == di)) begin
                    n_fail++; $display("FAIL equiv_co D=%0d k=%0d: got %b want %b", di, k, co, k == di);
                end
                step();
            end
            cnt = 1'b1;
            step();
            cnt = 1'b0;
            n_checks++;
            if (pout !== 4'h0 || co !== 1'b0) begin
                n_fail++; $display("FAIL equiv_wrap D=%0d: got pout=%h co=%b want 0/0", di, pout, co);
            end
        end
    endtask

    task automatic test_reset_mid();
        ld = 1'b1; cnt = 1'b0; pin = 4'hE;
        step();
        ld = 1'b0; cnt = 1'b1;
        step();
        n_checks++;
        if (pout !== 4'hF || co !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got pout=%h co=%b want f/1", pout, co);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (pout !== 4'h0 || co !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_rst: got pout=%h co=%b want 0/0", pout, co);
        end
        rst = 1'b0; cnt = 1'b0;
        step();
        n_checks++;
        if (pout !== 4'h0) begin n_fail++; $display("FAIL rstmid_noinc: got %h want 0", pout); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; ld = 1'b0; cnt = 1'b0; pin = 4'h0;
        #2;
        test_reset();
        test_wrap();
        test_load_priority();
        test_hold();
        test_equiv();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
